// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with a per-register pending scoreboard and registered, bypassed reads.
// Optional macro RF_ZERO_REG_EN: register 0 reads as zero, ignores writes and reservations.
module reg_file_sb #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SEL_W-1:0]    rd_sel_0,
    input  logic                rd_en_0,
    input  logic [SEL_W-1:0]    rd_sel_1,
    input  logic                rd_en_1,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [SEL_W-1:0]    rsv_sel,
    input  logic                rsv_en,
    output logic [DATA_W-1:0]   rd_data_0,
    output logic                rd_vld_0,
    output logic [DATA_W-1:0]   rd_data_1,
    output logic                rd_vld_1,
    output logic [NUM_REGS-1:0] pending
);

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    logic [SEL_W-1:0]    rd_sel [2];
    logic                rd_en  [2];
    logic [DATA_W-1:0]   rd_data_q [2];
    logic [DATA_W-1:0]   rd_data_d [2];
    logic [1:0]          rd_vld_q;
    logic [1:0]          rd_vld_d;

    assign rd_sel[0] = rd_sel_0;
    assign rd_sel[1] = rd_sel_1;
    assign rd_en[0]  = rd_en_0;
    assign rd_en[1]  = rd_en_1;

    function automatic logic in_range(input logic [SEL_W-1:0] s);
        return 32'(s) < 32'(NUM_REGS);
    endfunction

    // Per-register update: a same-cycle reservation beats the write's pending clear.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic wr_hit;
            logic rsv_hit;
            assign wr_hit  = wr_en  && (wr_sel  == SEL_W'(gi)) && !(ZERO_REG && gi == 0);
            assign rsv_hit = rsv_en && (rsv_sel == SEL_W'(gi)) && !(ZERO_REG && gi == 0);
            assign regs_d[gi]    = wr_hit ? wr_data : regs_q[gi];
            assign pending_d[gi] = rsv_hit | (pending_q[gi] & ~wr_hit);
        end

        // Reads see current-state pending; same-cycle reservations show up one cycle later.
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rd_data_d[gi] = '0;
                rd_vld_d[gi]  = 1'b0;
                if (rd_en[gi] && in_range(rd_sel[gi])) begin
                    if (ZERO_REG && rd_sel[gi] == '0) begin
                        rd_vld_d[gi] = 1'b1;
                    end else if (wr_en && wr_sel == rd_sel[gi]) begin
                        rd_data_d[gi] = wr_data;
                        rd_vld_d[gi]  = 1'b1;
                    end else begin
                        rd_data_d[gi] = regs_q[rd_sel[gi]];
                        rd_vld_d[gi]  = !pending_q[rd_sel[gi]];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q    <= '0;
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            rd_vld_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q    <= pending_d;
            rd_data_q[0] <= rd_data_d[0];
            rd_data_q[1] <= rd_data_d[1];
            rd_vld_q     <= rd_vld_d;
        end
    end

    assign rd_data_0 = rd_data_q[0];
    assign rd_vld_0  = rd_vld_q[0];
    assign rd_data_1 = rd_data_q[1];
    assign rd_vld_1  = rd_vld_q[1];
    assign pending   = pending_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: the driver queues expected read/pending results, a monitor checks them.
module tb_reg_file_sb;
    localparam int DATA_W = 8;
    localparam int NUM_REGS = 8;
    localparam int SEL_W = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [SEL_W-1:0]    rd_sel_0 = '0, rd_sel_1 = '0, wr_sel = '0, rsv_sel = '0;
    logic                rd_en_0 = 1'b0, rd_en_1 = 1'b0, wr_en = 1'b0, rsv_en = 1'b0;
    logic [DATA_W-1:0]   wr_data = '0;
    logic [DATA_W-1:0]   rd_data_0, rd_data_1;
    logic                rd_vld_0, rd_vld_1;
    logic [NUM_REGS-1:0] pending;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              v;
    } rd_exp_t;

    rd_exp_t             q0[$];
    rd_exp_t             q1[$];
    logic [NUM_REGS-1:0] qp[$];
    logic                chk0 = 1'b0, chk1 = 1'b0, chkp = 1'b0;
    int                  checks = 0;
    int                  passed = 0;
    int                  vec = 0;

    reg_file_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset),
        .rd_sel_0(rd_sel_0), .rd_en_0(rd_en_0),
        .rd_sel_1(rd_sel_1), .rd_en_1(rd_en_1),
        .wr_sel(wr_sel), .wr_en(wr_en), .wr_data(wr_data),
        .rsv_sel(rsv_sel), .rsv_en(rsv_en),
        .rd_data_0(rd_data_0), .rd_vld_0(rd_vld_0),
        .rd_data_1(rd_data_1), .rd_vld_1(rd_vld_1),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // Monitor: results for inputs driven before an edge are checked 1 time unit after it.
    always @(posedge clk) begin
        rd_exp_t e;
        #1;
        if (chk0) begin
            checks++;
            if (q0.size() == 0) begin
                $display("FAIL port0 vec %0d: output present but no expectation queued", vec);
            end else begin
                e = q0.pop_front();
                if (rd_data_0 === e.d && rd_vld_0 === e.v) passed++;
                else $display("FAIL port0 vec %0d: got data=%h vld=%b, want data=%h vld=%b",
                              vec, rd_data_0, rd_vld_0, e.d, e.v);
            end
        end
        if (chk1) begin
            checks++;
            if (q1.size() == 0) begin
                $display("FAIL port1 vec %0d: output present but no expectation queued", vec);
            end else begin
                e = q1.pop_front();
                if (rd_data_1 === e.d && rd_vld_1 === e.v) passed++;
                else $display("FAIL port1 vec %0d: got data=%h vld=%b, want data=%h vld=%b",
                              vec, rd_data_1, rd_vld_1, e.d, e.v);
            end
        end
        if (chkp) begin
            logic [NUM_REGS-1:0] ep;
            checks++;
            if (qp.size() == 0) begin
                $display("FAIL pending vec %0d: no expectation queued", vec);
            end else begin
                ep = qp.pop_front();
                if (pending === ep) passed++;
                else $display("FAIL pending vec %0d: got %h, want %h", vec, pending, ep);
            end
        end
        if (chk0 || chk1 || chkp)
            $display("vec %0d: rd0=%h/%b rd1=%h/%b pending=%h", vec, rd_data_0, rd_vld_0,
                     rd_data_1, rd_vld_1, pending);
    end

    // One clock of stimulus; c0/c1/cp select which results are expected after the edge.
    task automatic step(
        input logic rst,
        input logic we, input logic [SEL_W-1:0] ws, input logic [DATA_W-1:0] wd,
        input logic re, input logic [SEL_W-1:0] rs,
        input logic e0, input logic [SEL_W-1:0] s0,
        input logic e1, input logic [SEL_W-1:0] s1,
        input logic c0, input logic [DATA_W-1:0] d0, input logic v0,
        input logic c1, input logic [DATA_W-1:0] d1, input logic v1,
        input logic cp, input logic [NUM_REGS-1:0] p
    );
        rd_exp_t e;
        @(negedge clk);
        vec++;
        reset = rst;
        wr_en = we; wr_sel = ws; wr_data = wd;
        rsv_en = re; rsv_sel = rs;
        rd_en_0 = e0; rd_sel_0 = s0;
        rd_en_1 = e1; rd_sel_1 = s1;
        chk0 = c0; chk1 = c1; chkp = cp;
        if (c0) begin e.d = d0; e.v = v0; q0.push_back(e); end
        if (c1) begin e.d = d1; e.v = v1; q1.push_back(e); end
        if (cp) qp.push_back(p);
    endtask

    task automatic idle();
        step(0, 0,0,8'h00, 0,0, 0,0, 0,0, 0,8'h00,0, 0,8'h00,0, 0,8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam bit ZR =
`ifdef RF_ZERO_REG_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        // Reset overrides reads issued in the same cycle
        step(1, 1,3'd1,8'hEE, 1,3'd1, 1,3'd0, 1,3'd7, 1,8'h00,0, 1,8'h00,0, 1,8'h00);
        step(1, 0,0,8'h00, 0,0, 1,3'd1, 1,3'd1, 1,8'h00,0, 1,8'h00,0, 1,8'h00);
        for (int r = 0; r < 8; r++)
            step(0, 0,0,8'h00, 0,0, 1,3'(r), 1,3'(7-r), 1,8'h00,1, 1,8'h00,1, 1,8'h00);
        // Write then read next cycle
        step(0, 1,3'd3,8'hA5, 0,0, 0,0, 0,0, 0,8'h00,0, 0,8'h00,0, 1,8'h00);
        step(0, 0,0,8'h00, 0,0, 1,3'd3, 0,0, 1,8'hA5,1, 0,8'h00,0, 1,8'h00);
        // Bypass on port 1
        step(0, 1,3'd5,8'h3C, 0,0, 1,3'd3, 1,3'd5, 1,8'hA5,1, 1,8'h3C,1, 1,8'h00);
        // Reservation; same-cycle read unaffected
        step(0, 0,0,8'h00, 1,3'd2, 1,3'd2, 0,0, 1,8'h00,1, 0,8'h00,0, 1,8'h04);
        step(0, 0,0,8'h00, 0,0, 1,3'd2, 0,3'd2, 1,8'h00,0, 1,8'h00,0, 1,8'h04);
        // Writeback clears pending, bypass on both ports
        step(0, 1,3'd2,8'h11, 0,0, 1,3'd2, 1,3'd2, 1,8'h11,1, 1,8'h11,1, 1,8'h00);
        step(0, 0,0,8'h00, 0,0, 1,3'd2, 1,3'd5, 1,8'h11,1, 1,8'h3C,1, 1,8'h00);
        // Same-cycle write + reservation: reservation wins, data still stored
        step(0, 1,3'd4,8'h77, 1,3'd4, 0,0, 0,0, 0,8'h00,0, 0,8'h00,0, 1,8'h10);
        step(0, 0,0,8'h00, 0,0, 0,0, 1,3'd4, 0,8'h00,0, 1,8'h77,0, 1,8'h10);
        // Register 0 behaviour
        step(0, 1,3'd0,8'hFF, 0,0, 0,0, 0,0, 0,8'h00,0, 0,8'h00,0, 1,8'h10);
        step(0, 0,0,8'h00, 1,3'd0, 0,0, 0,0, 0,8'h00,0, 0,8'h00,0, 1, ZR ? 8'h10 : 8'h11);
        step(0, 0,0,8'h00, 0,0, 1,3'd0, 1,3'd0, 1, ZR ? 8'h00 : 8'hFF, ZR,
             1, ZR ? 8'h00 : 8'hFF, ZR, 1, ZR ? 8'h10 : 8'h11);
        step(0, 1,3'd0,8'h5A, 0,0, 1,3'd0, 0,0, 1, ZR ? 8'h00 : 8'h5A, 1,
             0,8'h00,0, 1,8'h10);
        // Build pending = 0x0F (0x0E with register 0 hardwired)
        step(0, 1,3'd4,8'h77, 0,0, 0,0, 0,0, 0,8'h00,0, 0,8'h00,0, 1,8'h00);
        step(0, 0,0,8'h00, 1,3'd0, 0,0, 0,0, 0,8'h00,0, 0,8'h00,0, 1, ZR ? 8'h00 : 8'h01);
        step(0, 0,0,8'h00, 1,3'd1, 0,0, 0,0, 0,8'h00,0, 0,8'h00,0, 1, ZR ? 8'h02 : 8'h03);
        step(0, 0,0,8'h00, 1,3'd2, 0,0, 0,0, 0,8'h00,0, 0,8'h00,0, 1, ZR ? 8'h06 : 8'h07);
        step(0, 0,0,8'h00, 1,3'd3, 0,0, 0,0, 0,8'h00,0, 0,8'h00,0, 1, ZR ? 8'h0E : 8'h0F);
        // Mid-operation reset with a same-cycle write
        step(1, 1,3'd1,8'h99, 0,0, 1,3'd3, 1,3'd1, 1,8'h00,0, 1,8'h00,0, 1,8'h00);
        step(0, 0,0,8'h00, 0,0, 1,3'd1, 1,3'd0, 1,8'h00,1, 1,8'h00,1, 1,8'h00);
        step(0, 0,0,8'h00, 0,0, 1,3'd3, 1,3'd5, 1,8'h00,1, 1,8'h00,1, 1,8'h00);
        idle();
        repeat (2) @(negedge clk);
        checks++;
        if (q0.size() == 0 && q1.size() == 0 && qp.size() == 0) passed++;
        else $display("FAIL drain: leftover q0=%0d q1=%0d qp=%0d, want 0/0/0",
                      q0.size(), q1.size(), qp.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
